// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing, lock-state enum and CRC-16 constants
package vga_pkg;

  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL  = 525;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One pixel's worth of CRC-16-CCITT, bit 23 first.
  function automatic logic [15:0] crc16_step24(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// rtl/vga_rx_crc16.sv - CRC-16-CCITT accumulator taking one 24-bit pixel per cycle
module vga_rx_crc16
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [23:0] data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step24(crc, data);
    end
  end

endmodule

// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA receiver: sync tracking, line/frame checks, lock FSM, pixel capture
// Optional per-frame CRC of visible pixels is built when VGA_RX_CRC_EN is defined.
module vga_rx
  import vga_pkg::*;
#(
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter logic SYNC_ACTIVE = 1'b1,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] rgb_in,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] frame_cnt,
  output logic [15:0] crc,
  output logic        crc_valid
);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END       = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END       = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [3:0] GOOD_TARGET = 4'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX     = 10'd1023;

  logic        hs_r, vs_r, hs_d, vs_d;
  logic [23:0] rgb_r;
  logic        hs_lead, vs_lead;

  logic [9:0]  h_cnt, v_cnt, h_next, v_next;
  logic        h_seen, v_seen;
  logic        err_h_c, err_v_c, sat_c, sat_r;
  logic        frame_err, frame_bad;
  logic        h_win, v_win, pix_en;
  logic [3:0]  good;
  lock_state_t state;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      rgb_r <= '0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      rgb_r <= rgb_in;
    end
  end

  assign hs_lead = (hs_r == SYNC_ACTIVE) && (hs_d != SYNC_ACTIVE);
  assign vs_lead = (vs_r == SYNC_ACTIVE) && (vs_d != SYNC_ACTIVE);

  // h_next/v_next are the coordinates of the sample now sitting in the input register.
  always_comb begin
    h_next  = h_cnt;
    v_next  = v_cnt;
    err_h_c = 1'b0;
    err_v_c = 1'b0;
    sat_c   = 1'b0;
    if (hs_lead) begin
      h_next  = '0;
      err_h_c = h_seen && (h_cnt != H_LAST);
    end else if (h_cnt == CNT_MAX - 10'd1) begin
      h_next = CNT_MAX;
      sat_c  = 1'b1;
    end else if (h_cnt != CNT_MAX) begin
      h_next = h_cnt + 10'd1;
    end
    if (vs_lead) begin
      v_next  = '0;
      err_v_c = v_seen && (v_cnt != V_LAST);
    end else if (hs_lead && (v_cnt != CNT_MAX)) begin
      v_next = v_cnt + 10'd1;
    end
    h_win     = (h_next >= H_START) && (h_next < H_END);
    v_win     = (v_next >= V_START) && (v_next < V_END);
    frame_bad = frame_err | err_h_c | err_v_c | sat_c;
  end

  assign pix_en = h_win && v_win && (state == LOCKED);
  assign locked = (state == LOCKED);

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      sat_r       <= 1'b0;
      frame_err   <= 1'b0;
      good        <= '0;
      state       <= HUNT;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      pix_valid   <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      pix_data    <= '0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      err_h       <= err_h_c | sat_c;
      err_v       <= err_v_c;
      sat_r       <= sat_c;
      frame_start <= vs_lead;
      frame_err   <= vs_lead ? 1'b0 : (frame_err | err_h_c | err_v_c | sat_c);

      // Losing horizontal timing re-arms the first-edge exemption for both axes.
      if (sat_c) begin
        h_seen <= 1'b0;
        v_seen <= 1'b0;
      end else begin
        if (hs_lead) h_seen <= 1'b1;
        if (vs_lead) v_seen <= 1'b1;
      end

      pix_valid <= pix_en;
      if (pix_en) begin
        pos_x    <= h_next - H_START;
        pos_y    <= v_next - V_START;
        pix_data <= rgb_r;
      end

      if (vs_lead && (state == LOCKED)) frame_cnt <= frame_cnt + 16'd1;

      case (state)
        HUNT: begin
          if (vs_lead) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        ACQUIRE: begin
          if (sat_r) begin
            state <= HUNT;
          end else if (vs_lead) begin
            if (frame_bad) begin
              good <= '0;
            end else if (good + 4'd1 >= GOOD_TARGET) begin
              state <= LOCKED;
              good  <= '0;
            end else begin
              good <= good + 4'd1;
            end
          end
        end
        LOCKED: begin
          // Reacts to the registered error pulse so locked drops one cycle after it.
          if (sat_r) begin
            state <= HUNT;
          end else if (err_h || err_v) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc;

  vga_rx_crc16 u_crc16 (
    .clk  (vga_clk),
    .rst  (sys_rst),
    .clr  (vs_lead),
    .en   (pix_en),
    .data (rgb_r),
    .crc  (crc_acc)
  );

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      crc       <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= vs_lead && (state == LOCKED) && !frame_bad;
      if (vs_lead && (state == LOCKED) && !frame_bad) crc <= crc_acc;
    end
  end
`else
  assign crc       = '0;
  assign crc_valid = 1'b0;
`endif

endmodule
